// File: rtl/mux_scan_if.sv
// Channel bus for mux_scan_nx1: mode/scan controls and packed channel data in,
// registered selection, strobes and status out.
interface mux_scan_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
);
  localparam int unsigned SW = $clog2(N);

  logic              mode;
  logic              start;
  logic              hold;
  logic [SW-1:0]     sel_in;
  logic [N*W-1:0]    din;
  logic [W-1:0]      y;
  logic              y_valid;
  logic [SW-1:0]     sel_out;
  logic              busy;
  logic              done;

  modport master (
    output mode, start, hold, sel_in, din,
    input  y, y_valid, sel_out, busy, done
  );

  modport slave (
    input  mode, start, hold, sel_in, din,
    output y, y_valid, sel_out, busy, done
  );
endinterface

// File: rtl/mux_scan_nx1.sv
// N:1 W-bit multiplexer with registered output; selection comes either from
// sel_in (manual) or from an internal one-shot sweep of all channels (scan).
module mux_scan_nx1 #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);

  localparam int unsigned  SW     = $clog2(N);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_EXT = (SW + 1)'(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]    r_state;
  logic [SW-1:0] r_idx;
  logic [W-1:0]  r_y;
  logic          r_y_valid;
  logic [SW-1:0] r_sel_out;
  logic          r_busy;
  logic          r_done;

  logic [0:0]    w_state_nxt;
  logic [SW-1:0] w_idx_nxt;
  logic [W-1:0]  w_y_nxt;
  logic          w_y_valid_nxt;
  logic [SW-1:0] w_sel_out_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_sel_in_range;

  // Compare-based select so out-of-range indices never address din.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                        input logic [SW-1:0]  s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (s == SW'(k)) r = d[k*W +: W];
    end
    return r;
  endfunction

  assign w_sel_in_range = ({1'b0, bus.sel_in} < N_EXT);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_y_nxt       = r_y;
    w_y_valid_nxt = 1'b0;
    w_sel_out_nxt = r_sel_out;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!bus.mode) begin
          w_sel_out_nxt = bus.sel_in;
          w_y_nxt       = w_sel_in_range ? pick(bus.din, bus.sel_in) : '0;
          w_y_valid_nxt = w_sel_in_range;
        end else if (bus.start) begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SCAN: begin
        // hold freezes the index and suppresses the strobe; y/sel_out keep value
        if (!bus.hold) begin
          w_y_nxt       = pick(bus.din, r_idx);
          w_sel_out_nxt = r_idx;
          w_y_valid_nxt = 1'b1;
          if (r_idx == LAST) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_sel_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
      r_sel_out <= w_sel_out_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;
  assign bus.sel_out = r_sel_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: an 8x1 instance for manual/scan/hold/reset
// behaviour and a 6x4 instance for out-of-range manual selects.
module tb_mux_scan_nx1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mux_scan_if #(.N(8), .W(1)) if_a ();
  mux_scan_if #(.N(6), .W(4)) if_b ();

  mux_scan_nx1 #(.N(8), .W(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mux_scan_nx1 #(.N(6), .W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed channel values of din = 8'hA6, channel 0 first
  int unsigned exp_a6 [8] = '{0, 1, 1, 0, 0, 1, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int unsigned y, input int unsigned vld,
                       input int unsigned sel, input int unsigned bsy, input int unsigned dn);
    chk({tag, ".y"},       32'(if_a.y),       32'(y));
    chk({tag, ".y_valid"}, 32'(if_a.y_valid), 32'(vld));
    chk({tag, ".sel_out"}, 32'(if_a.sel_out), 32'(sel));
    chk({tag, ".busy"},    32'(if_a.busy),    32'(bsy));
    chk({tag, ".done"},    32'(if_a.done),    32'(dn));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if_a.mode = 1'b0; if_a.start = 1'b0; if_a.hold = 1'b0;
    if_a.sel_in = '0; if_a.din = 8'hA6;
    if_b.mode = 1'b0; if_b.start = 1'b0; if_b.hold = 1'b0;
    if_b.sel_in = '0; if_b.din = 24'h654321;

    // Reset state
    #3;
    chk_a("rst_a", 0, 0, 0, 0, 0);
    chk("rst_b.y", 32'(if_b.y), 32'd0);
    chk("rst_b.y_valid", 32'(if_b.y_valid), 32'd0);
    #9 rst_n = 1'b1;

    // Manual select on the 6-channel bus, including invalid indices 6 and 7
    if_b.sel_in = 3'd5;
    tick();
    chk("b_sel5.y", 32'(if_b.y), 32'h6);
    chk("b_sel5.y_valid", 32'(if_b.y_valid), 32'd1);
    chk("b_sel5.sel_out", 32'(if_b.sel_out), 32'd5);
    for (int s = 6; s < 8; s++) begin
      if_b.sel_in = 3'(s);
      tick();
      chk($sformatf("b_sel%0d.y", s), 32'(if_b.y), 32'd0);
      chk($sformatf("b_sel%0d.y_valid", s), 32'(if_b.y_valid), 32'd0);
      chk($sformatf("b_sel%0d.sel_out", s), 32'(if_b.sel_out), 32'(s));
    end

    // Manual sweep of 8-channel bus
    for (int k = 0; k < 8; k++) begin
      if_a.sel_in = 3'(k);
      tick();
      chk_a($sformatf("man%0d", k), exp_a6[k], 1, k, 0, 0);
    end

    // Plain scan
    if_a.mode = 1'b1; if_a.start = 1'b1; if_a.sel_in = 3'd3;
    tick();
    if_a.start = 1'b0;
    chk_a("scan_start", exp_a6[7], 0, 7, 1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_a($sformatf("scan%0d", k), exp_a6[k], 1, k, (k < 7) ? 1 : 0, (k == 7) ? 1 : 0);
    end
    tick();
    chk_a("scan_after", exp_a6[7], 0, 7, 0, 0);

    // Scan with a 2-cycle hold after channel 2
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk_a("hscan_start", exp_a6[7], 0, 7, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a($sformatf("hscan%0d", k), exp_a6[k], 1, k, 1, 0);
    end
    if_a.hold = 1'b1;
    for (int h = 0; h < 2; h++) begin
      tick();
      chk_a($sformatf("hold%0d", h), exp_a6[2], 0, 2, 1, 0);
    end
    if_a.hold = 1'b0;
    for (int k = 3; k < 8; k++) begin
      tick();
      chk_a($sformatf("hscan%0d", k), exp_a6[k], 1, k, (k < 7) ? 1 : 0, (k == 7) ? 1 : 0);
    end

    // Scan ignoring start/mode/sel_in mid-way, then back-to-back restart
    tick();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk_a("iscan_start", exp_a6[7], 0, 7, 1, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin if_a.start = 1'b1; if_a.mode = 1'b0; if_a.sel_in = 3'd6; end
      if (k == 4) if_a.start = 1'b0;
      if (k == 6) if_a.mode = 1'b1;
      tick();
      chk_a($sformatf("iscan%0d", k), exp_a6[k], 1, k, (k < 7) ? 1 : 0, (k == 7) ? 1 : 0);
    end
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk_a("b2b_start", exp_a6[7], 0, 7, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_a($sformatf("b2b%0d", k), exp_a6[k], 1, k, 1, 0);
    end

    // Asynchronous reset between edges while sel_out = 4
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk_a("rscan_start", 0, 0, 0, 1, 0);
    tick();
    chk_a("rscan0", exp_a6[0], 1, 0, 1, 0);
    tick();
    chk_a("rscan1", exp_a6[1], 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
